// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for NUM_DIGITS seven-segment
// digits sharing one segment bus. Each digit is scanned round-robin with a
// dark BLANK gap (anti-ghosting) followed by a lit SHOW dwell.
// Optional build macro SEVEN_SEG_LZ_BLANK_EN adds leading-zero suppression;
// when it is undefined every digit always shows its hex glyph.
//
// Write port handshake: wr_en acts as a valid strobe and the block is always
// ready, so every cycle with wr_en=1 and wr_addr<NUM_DIGITS commits one
// digit write at that clock edge, in any scan state. Out-of-range addresses
// are dropped silently.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 100,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  output logic [6:0]            seg_out,
  output logic                  seg_dp,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [3:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_q;

  // seg_q / seg_dp_q double as the glyph shadow: they are loaded only on the
  // BLANK->SHOW edge, so later writes cannot disturb the lit digit.
  logic [6:0]            seg_q;
  logic                  seg_dp_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  frame_done_q;

  // Combinational helpers feeding the registers.
  logic [3:0]            cur_val_d;
  logic                  cur_dp_d;
  logic                  lz_blank_d;
  logic [6:0]            glyph_d;
  logic [IDX_W-1:0]      idx_nxt_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Select the stored value and dp of the digit currently being scanned.
  always_comb begin
    cur_val_d = 4'h0;
    cur_dp_d  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_val_d = digit_q[i];
        cur_dp_d  = dp_q[i];
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Suppress a zero digit when every more-significant digit is also zero;
  // digit 0 always lights so a value of zero still shows "0".
  always_comb begin
    lz_blank_d = (idx_q != '0) && (cur_val_d == 4'h0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i > int'(idx_q) && digit_q[i] != 4'h0) begin
        lz_blank_d = 1'b0;
      end
    end
  end
`else
  assign lz_blank_d = 1'b0;
`endif

  assign glyph_d   = lz_blank_d ? 7'h00 : hex_to_seg(cur_val_d);
  assign idx_nxt_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // Digit register file: writes land in any state; reset clears contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= 4'h0;
      end
      dp_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == 3'(i)) begin
          digit_q[i] <= wr_data;
          dp_q[i]    <= wr_dp;
        end
      end
    end
  end

  // Scan FSM with registered outputs; enable low forces OFF from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      seg_q        <= 7'h00;
      seg_dp_q     <= 1'b0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!enable) begin
        state_q  <= ST_OFF;
        idx_q    <= '0;
        cnt_q    <= '0;
        seg_q    <= 7'h00;
        seg_dp_q <= 1'b0;
        sel_q    <= '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            state_q  <= ST_BLANK;
            idx_q    <= '0;
            cnt_q    <= '0;
            seg_q    <= 7'h00;
            seg_dp_q <= 1'b0;
            sel_q    <= '0;
          end
          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q  <= ST_SHOW;
              cnt_q    <= '0;
              seg_q    <= glyph_d;
              seg_dp_q <= cur_dp_d;
              sel_q    <= NUM_DIGITS'(1) << idx_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_SHOW: begin
            if (cnt_q == DWELL_LAST) begin
              state_q      <= ST_BLANK;
              cnt_q        <= '0;
              idx_q        <= idx_nxt_d;
              seg_q        <= 7'h00;
              seg_dp_q     <= 1'b0;
              sel_q        <= '0;
              frame_done_q <= (idx_q == IDX_LAST);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q  <= ST_OFF;
            idx_q    <= '0;
            cnt_q    <= '0;
            seg_q    <= 7'h00;
            seg_dp_q <= 1'b0;
            sel_q    <= '0;
          end
        endcase
      end
    end
  end

  assign seg_out    = seg_q;
  assign seg_dp     = seg_dp_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed scenarios for seven_seg_scanner with
// NUM_DIGITS=4, DWELL=8, BLANK=2. The driver pushes expected lit periods,
// frame_done times and dark-state checks into queues; the monitor pops
// and compares whenever the DUT presents a lit digit, a frame_done pulse
// or reaches a scheduled dark cycle.
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int DW = 8;
  localparam int BL = 2;
  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic [6:0]    seg_out;
  logic          seg_dp;
  logic [ND-1:0] digit_sel;
  logic          frame_done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .CNT_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .seg_out   (seg_out),
    .seg_dp    (seg_dp),
    .digit_sel (digit_sel),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard queues ----------------
  // exp_q entry: {start_cycle[31:0], len[3:0], sel[3:0], dp, seg[6:0]}
  logic [47:0] exp_q[$];
  logic [31:0] fd_q[$];
  // dark_q entry: {cycle[31:0], state[1:0]}
  logic [33:0] dark_q[$];
  logic        done = 1'b0;
  int          n0 = 0;

  // Expected glyphs for an all-zero upper bank depend on the build option.
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [6:0] ZERO_UPPER = 7'h00;
`else
  localparam logic [6:0] ZERO_UPPER = 7'h3F;
`endif

  // ---------------- driver tasks ----------------
  task automatic push_lit(input int start, input int len, input logic [3:0] sel,
                          input logic dp, input logic [6:0] seg);
    exp_q.push_back({32'(start), 4'(len), sel, dp, seg});
  endtask

  task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic dp0);
    push_lit(base + 2,  DW, 4'b0001, dp0,  s0);
    push_lit(base + 12, DW, 4'b0010, 1'b0, s1);
    push_lit(base + 22, DW, 4'b0100, 1'b0, s2);
    push_lit(base + 32, DW, 4'b1000, 1'b0, s3);
    fd_q.push_back(32'(base + 40));
  endtask

  task automatic push_dark(input int at, input logic [1:0] st);
    dark_q.push_back({32'(at), st});
  endtask

  task automatic goto(input int k);
    while (cyc < n0 + k) @(negedge clk);
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_scan();
    enable = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    push_dark(n0, ST_BLANK);
    push_dark(n0 + 1, ST_BLANK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0;
    wr_addr = 3'd0; wr_data = 4'h0; wr_dp = 1'b0;
    repeat (3) @(negedge clk);
    push_dark(cyc + 1, ST_OFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Digits 3..0 = 1,2,3,4 then scan.
    write_digit(3'd3, 4'h1, 1'b0);
    write_digit(3'd2, 4'h2, 1'b0);
    write_digit(3'd1, 4'h3, 1'b0);
    write_digit(3'd0, 4'h4, 1'b0);
    start_scan();
    push_frame(n0,      7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0);
    push_frame(n0 + 40, 7'h71, 7'h4F, 7'h5B, 7'h06, 1'b1);
    push_frame(n0 + 80, 7'h71, 7'h4F, 7'h5B, 7'h06, 1'b1);
    push_lit(n0 + 122, DW, 4'b0001, 1'b1, 7'h71);
    push_lit(n0 + 132, DW, 4'b0010, 1'b0, 7'h4F);
    push_lit(n0 + 142, 3,  4'b0100, 1'b0, 7'h5B);

    // Digit 0 = F/dp while digit 0 is lit: visible only from the next frame.
    goto(4);
    write_digit(3'd0, 4'hF, 1'b1);
    // Out-of-range write must change nothing.
    goto(50);
    write_digit(3'd5, 4'h9, 1'b1);
    // Drop enable three cycles into digit 2's dwell of frame 3.
    goto(144);
    enable = 1'b0;
    push_dark(n0 + 145, ST_OFF);

    // Re-enable restarts from BLANK with digit 0; reset during digit 1.
    goto(150);
    start_scan();
    push_lit(n0 + 2,  DW, 4'b0001, 1'b1, 7'h71);
    push_lit(n0 + 12, 3,  4'b0010, 1'b0, 7'h4F);
    goto(14);
    rst_n = 1'b0;
    push_dark(n0 + 15, ST_OFF);
    goto(15);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    push_dark(n0, ST_BLANK);
    push_dark(n0 + 1, ST_BLANK);
    push_frame(n0, 7'h3F, ZERO_UPPER, ZERO_UPPER, ZERO_UPPER, 1'b0);
    goto(40);
    enable = 1'b0;
    push_dark(n0 + 41, ST_OFF);

    // Digits 3..0 = 0,0,7,0: leading-zero case.
    goto(42);
    write_digit(3'd3, 4'h0, 1'b0);
    write_digit(3'd2, 4'h0, 1'b0);
    write_digit(3'd1, 4'h7, 1'b0);
    write_digit(3'd0, 4'h0, 1'b0);
    start_scan();
    push_frame(n0, 7'h3F, 7'h07, ZERO_UPPER, ZERO_UPPER, 1'b0);
    goto(40);
    enable = 1'b0;
    goto(44);
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [ND-1:0] prev_sel = '0;
  int          run_len = 0;
  logic [11:0] run_val = '0;
  logic [47:0] cur_exp = '0;
  logic [33:0] dk;
  logic [31:0] fd_exp;

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (!$onehot0(digit_sel)) begin
        errors++;
        $display("FAIL onehot0 cyc=%0d digit_sel=%b required zero or one-hot", cyc, digit_sel);
      end
      checks++;
      if (digit_sel == '0 && (seg_out != 7'h00 || seg_dp != 1'b0)) begin
        errors++;
        $display("FAIL dark_segs cyc=%0d seg_out=%h seg_dp=%b required 00/0", cyc, seg_out, seg_dp);
      end

      if (dark_q.size() != 0 && int'(dark_q[0][33:2]) <= cyc) begin
        dk = dark_q.pop_front();
        checks++;
        if (int'(dk[33:2]) != cyc) begin
          errors++;
          $display("FAIL dark_sched cyc=%0d required cyc=%0d", cyc, dk[33:2]);
        end else if (digit_sel != '0 || seg_out != 7'h00 || seg_dp || frame_done || dbg_state != dk[1:0]) begin
          errors++;
          $display("FAIL dark cyc=%0d sel=%b seg=%h dp=%b fd=%b st=%0d required 0/00/0/0 st=%0d",
                   cyc, digit_sel, seg_out, seg_dp, frame_done, dbg_state, dk[1:0]);
        end
      end

      if (digit_sel != '0) begin
        if (prev_sel == '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            cur_exp = '0;
            $display("FAIL unexpected_lit cyc=%0d sel=%b seg=%h", cyc, digit_sel, seg_out);
          end else begin
            cur_exp = exp_q.pop_front();
            if ({32'(cyc), digit_sel, seg_dp, seg_out} != {cur_exp[47:16], cur_exp[11:0]}) begin
              errors++;
              $display("FAIL lit_start cyc=%0d sel=%b dp=%b seg=%h required cyc=%0d sel=%b dp=%b seg=%h",
                       cyc, digit_sel, seg_dp, seg_out, cur_exp[47:16], cur_exp[11:8],
                       cur_exp[7], cur_exp[6:0]);
            end
          end
          run_len = 1;
          run_val = {digit_sel, seg_dp, seg_out};
        end else begin
          checks++;
          if ({digit_sel, seg_dp, seg_out} != run_val) begin
            errors++;
            $display("FAIL lit_stable cyc=%0d got=%h required=%h", cyc,
                     {digit_sel, seg_dp, seg_out}, run_val);
          end
          run_len++;
        end
      end else if (prev_sel != '0) begin
        checks++;
        if (run_len != int'(cur_exp[15:12])) begin
          errors++;
          $display("FAIL lit_len cyc=%0d sel=%b len=%0d required %0d", cyc, prev_sel,
                   run_len, cur_exp[15:12]);
        end
      end

      if (frame_done) begin
        checks++;
        if (fd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_done cyc=%0d", cyc);
        end else begin
          fd_exp = fd_q.pop_front();
          if (cyc != int'(fd_exp)) begin
            errors++;
            $display("FAIL frame_done_time cyc=%0d required %0d", cyc, fd_exp);
          end
        end
      end
      prev_sel = digit_sel;

      if (done) begin
        checks++;
        if (exp_q.size() != 0 || fd_q.size() != 0 || dark_q.size() != 0) begin
          errors++;
          $display("FAIL leftover lit=%0d frame_done=%0d dark=%0d required 0/0/0",
                   exp_q.size(), fd_q.size(), dark_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (cyc > 5000) begin
        checks++;
        errors++;
        $display("FAIL timeout cyc=%0d required finish before 5000", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
